// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the two-master Wishbone arbiter.
package wb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      ABORT = 2'd2
   } arb_state_t;

   localparam int NUM_MASTERS = 2;

   // One-hot grant vector for a one-bit owner index (0 -> 01, 1 -> 10).
   function automatic logic [NUM_MASTERS-1:0] owner_onehot(input logic owner);
      return owner ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Bus-timeout watchdog: counts consecutive strobe cycles without an ack and
// flags expiry on the last allowed cycle.
module wb_arb_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic i_stb,
   input  logic i_ack,
   output logic o_expire
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

   logic [CW-1:0] wcnt_q;
   logic [CW-1:0] wcnt_d;

   // Next count: restart whenever the strobe is gone or the slave answers.
   always_comb begin
      if (!i_stb || i_ack) begin
         wcnt_d = '0;
      end else begin
         wcnt_d = wcnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
   end

   // Expiry fires only while still waiting; an ack on the same cycle wins.
   always_comb begin
      o_expire = i_stb && !i_ack && (wcnt_q == LIMIT);
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wcnt_q <= '0;
      end else begin
         wcnt_q <= wcnt_d;
      end
   end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master classic Wishbone arbiter: round-robin grant held for a whole
// cyc, combinational routing of the owner onto the slave port, and a
// watchdog that terminates a hung transfer with err.
module wb_arbiter_2m
   import wb_arb_pkg::*;
#(
   parameter int AW      = 26,
   parameter int DW      = 32,
   parameter int TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_m0_cyc,
   input  logic                   i_m0_stb,
   input  logic                   i_m0_we,
   input  logic [AW-1:0]          i_m0_adr,
   input  logic [DW-1:0]          i_m0_dat,
   output logic                   o_m0_ack,
   output logic                   o_m0_err,
   output logic [DW-1:0]          o_m0_dat,
   input  logic                   i_m1_cyc,
   input  logic                   i_m1_stb,
   input  logic                   i_m1_we,
   input  logic [AW-1:0]          i_m1_adr,
   input  logic [DW-1:0]          i_m1_dat,
   output logic                   o_m1_ack,
   output logic                   o_m1_err,
   output logic [DW-1:0]          o_m1_dat,
   output logic                   o_s_cyc,
   output logic                   o_s_stb,
   output logic                   o_s_we,
   output logic [AW-1:0]          o_s_adr,
   output logic [DW-1:0]          o_s_dat,
   input  logic                   i_s_ack,
   input  logic [DW-1:0]          i_s_dat,
   output logic [NUM_MASTERS-1:0] o_grant,
   output logic                   o_timeout
);

   arb_state_t    state_q, state_d;
   logic          owner_q, owner_d;
   logic          last_q, last_d;

   logic          own_cyc_s;
   logic          own_stb_s;
   logic          own_we_s;
   logic [AW-1:0] own_adr_s;
   logic [DW-1:0] own_dat_s;
   logic          busy_s;
   logic          expire_s;

   // Select the current owner's request lines.
   always_comb begin
      own_cyc_s = owner_q ? i_m1_cyc : i_m0_cyc;
      own_stb_s = owner_q ? i_m1_stb : i_m0_stb;
      own_we_s  = owner_q ? i_m1_we  : i_m0_we;
      own_adr_s = owner_q ? i_m1_adr : i_m0_adr;
      own_dat_s = owner_q ? i_m1_dat : i_m0_dat;
      busy_s    = (state_q == BUSY);
   end

   wb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .i_stb    (o_s_stb),
      .i_ack    (i_s_ack),
      .o_expire (expire_s)
   );

   // Arbitration: pick an owner from IDLE, release on owner's cyc drop,
   // divert to ABORT when the watchdog expires.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (i_m0_cyc && i_m1_cyc) begin
               owner_d = ~last_q;
               state_d = BUSY;
            end else if (i_m0_cyc) begin
               owner_d = 1'b0;
               state_d = BUSY;
            end else if (i_m1_cyc) begin
               owner_d = 1'b1;
               state_d = BUSY;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (!own_cyc_s) begin
               last_d  = owner_q;
               state_d = IDLE;
            end else if (expire_s) begin
               state_d = ABORT;
            end else begin
               state_d = BUSY;
            end
         end
         ABORT: begin
            if (!own_cyc_s) begin
               last_d  = owner_q;
               state_d = IDLE;
            end else begin
               state_d = ABORT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM, owner and round-robin history registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

   // Route the owner onto the slave port and terminations back to it only;
   // acks arriving outside BUSY or after the owner left cyc are dropped.
   always_comb begin
      o_s_cyc   = busy_s && own_cyc_s;
      o_s_stb   = busy_s && own_cyc_s && own_stb_s;
      o_s_we    = busy_s ? own_we_s  : 1'b0;
      o_s_adr   = busy_s ? own_adr_s : '0;
      o_s_dat   = busy_s ? own_dat_s : '0;
      o_m0_ack  = i_s_ack && o_s_cyc && !owner_q;
      o_m1_ack  = i_s_ack && o_s_cyc &&  owner_q;
      o_m0_err  = expire_s && !owner_q;
      o_m1_err  = expire_s &&  owner_q;
      o_m0_dat  = (busy_s && !owner_q) ? i_s_dat : '0;
      o_m1_dat  = (busy_s &&  owner_q) ? i_s_dat : '0;
      o_timeout = expire_s;
      o_grant   = (state_q != IDLE) ? owner_onehot(owner_q) : 2'b00;
   end

endmodule
